// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths and FSM state type for the sequential divider
package div_pkg;

    localparam int DEF_DIVIDEND_W = 16;
    localparam int DEF_DIVISOR_W  = 8;
    localparam int CNT_W          = $clog2(DEF_DIVIDEND_W);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/seq_divider_restoring_step.sv
// rtl/seq_divider_restoring_step.sv - one combinational restoring-division iteration
module restoring_step #(
    parameter int W = 8
) (
    input  logic [W:0]   i_rem,
    input  logic         i_bit,
    input  logic [W-1:0] i_div,
    output logic [W:0]   o_rem,
    output logic         o_qbit
);

    logic [W:0] w_trial;

    // A set top bit of the running remainder means the trial value already exceeds any divisor.
    assign w_trial = {i_rem[W-1:0], i_bit};
    assign o_qbit  = i_rem[W] | (w_trial >= {1'b0, i_div});
    assign o_rem   = o_qbit ? (w_trial - {1'b0, i_div}) : w_trial;

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - unsigned restoring divider, one quotient bit per clock
module seq_divider
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CW = $clog2(DIVIDEND_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIVIDEND_W - 1);

    state_t                r_state;
    logic [DIVIDEND_W-1:0] r_q;
    logic [DIVISOR_W:0]    r_rem;
    logic [DIVISOR_W-1:0]  r_d;
    logic [CW-1:0]         r_cnt;
    logic                  r_dbz_pend;

    logic [DIVISOR_W:0]    w_rem_next;
    logic                  w_qbit;
    logic [DIVIDEND_W-1:0] w_q_next;
    logic                  w_accept;

    restoring_step #(.W(DIVISOR_W)) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_q[DIVIDEND_W-1]),
        .i_div  (r_d),
        .o_rem  (w_rem_next),
        .o_qbit (w_qbit)
    );

    assign w_q_next = {r_q[DIVIDEND_W-2:0], w_qbit};
    assign busy     = (r_state == RUN);
    // A pending divide-by-zero completion blocks acceptance for its single cycle.
    assign w_accept = (r_state == IDLE) && !r_dbz_pend && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_q         <= '0;
            r_rem       <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_dbz_pend  <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done       <= 1'b0;
            r_dbz_pend <= 1'b0;
            if (r_dbz_pend) begin
                quotient    <= '1;
                remainder   <= r_q[DIVISOR_W-1:0];
                div_by_zero <= 1'b1;
                done        <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_q   <= dividend;
                        r_d   <= divisor;
                        r_rem <= '0;
                        r_cnt <= '0;
                        if (divisor == '0) begin
                            r_dbz_pend <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_q   <= w_q_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        quotient    <= w_q_next;
                        remainder   <= w_rem_next[DIVISOR_W-1:0];
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider
module tb_seq_divider;

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    seq_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        if (b == 8'd0) begin
            e.q = 16'hFFFF;
            e.r = a[7:0];
            e.z = 1'b1;
        end else begin
            e.q = a / {8'd0, b};
            e.r = 8'(a % {8'd0, b});
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic issue(input logic [15:0] a, input logic [7:0] b);
        sb.push_back(model(a, b));
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                c = i;
                break;
            end
        end
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '1;
    endtask

    task automatic test_reset;
        #12;
        n_cmp++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 27'd0) begin
            n_err++;
            $display("FAIL reset_state got=%h want=0", {busy, done, quotient, remainder, div_by_zero});
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [15:0] a_tab [4] = '{16'd1000, 16'hFFFF, 16'hFFFF, 16'd5};
        logic [7:0]  b_tab [4] = '{8'd7,     8'hFF,    8'h01,    8'd9};
        exp_t e;
        exp_t got;
        int   c;
        for (int k = 0; k < 4; k++) begin
            issue(a_tab[k], b_tab[k]);
            wait_done(c);
            n_cmp++;
            if (c !== 16) begin
                n_err++;
                $display("FAIL basic_latency[%0d] got=%0d want=16", k, c);
            end
            pop_exp(e);
            got = {quotient, remainder, div_by_zero};
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL basic_result[%0d] got q=%h r=%h z=%b want q=%h r=%h z=%b",
                         k, got.q, got.r, got.z, e.q, e.r, e.z);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (done !== 1'b0 || quotient !== e.q) begin
                n_err++;
                $display("FAIL done_width[%0d] got done=%b q=%h want done=0 q=%h", k, done, quotient, e.q);
            end
        end
    endtask

    task automatic test_div_zero;
        exp_t e;
        exp_t got;
        int   c;
        issue(16'h12AB, 8'd0);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL dbz_busy_start got=%b want=0", busy);
        end
        wait_done(c);
        n_cmp++;
        if (c !== 1) begin
            n_err++;
            $display("FAIL dbz_latency got=%0d want=1", c);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL dbz_busy_done got=%b want=0", busy);
        end
        pop_exp(e);
        got = {quotient, remainder, div_by_zero};
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL dbz_result got q=%h r=%h z=%b want q=%h r=%h z=%b",
                     got.q, got.r, got.z, e.q, e.r, e.z);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start;
        exp_t e;
        exp_t got;
        int   c;
        issue(16'h4321, 8'h13);
        repeat (4) @(posedge clk);
        #1;
        dividend = 16'h0BAD;
        divisor  = 8'h05;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL ignore_busy got=%b want=1", busy);
        end
        wait_done(c);
        n_cmp++;
        if (c + 5 !== 16) begin
            n_err++;
            $display("FAIL ignore_latency got=%0d want=16", c + 5);
        end
        pop_exp(e);
        got = {quotient, remainder, div_by_zero};
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL ignore_result got q=%h r=%h want q=%h r=%h", got.q, got.r, e.q, e.r);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        exp_t got;
        int   c;
        issue(16'd50000, 8'd123);
        wait_done(c);
        pop_exp(e);
        got = {quotient, remainder, div_by_zero};
        n_cmp++;
        if (got !== e || c !== 16) begin
            n_err++;
            $display("FAIL b2b_first got q=%h r=%h c=%0d want q=%h r=%h c=16", got.q, got.r, c, e.q, e.r);
        end
        sb.push_back(model(16'd777, 8'd10));
        dividend = 16'd777;
        divisor  = 8'd10;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept busy got=%b want=1", busy);
        end
        wait_done(c);
        n_cmp++;
        if (c !== 16) begin
            n_err++;
            $display("FAIL b2b_latency got=%0d want=16", c);
        end
        pop_exp(e);
        got = {quotient, remainder, div_by_zero};
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL b2b_second got q=%h r=%h want q=%h r=%h", got.q, got.r, e.q, e.r);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run;
        exp_t e;
        exp_t got;
        int   c;
        bit   seen;
        issue(16'hBEEF, 8'h2D);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 27'd0) begin
            n_err++;
            $display("FAIL rst_async got=%h want=0", {busy, done, quotient, remainder, div_by_zero});
        end
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL rst_no_done got=%b want=0", seen);
        end
        issue(16'd9999, 8'd77);
        wait_done(c);
        pop_exp(e);
        got = {quotient, remainder, div_by_zero};
        n_cmp++;
        if (got !== e || c !== 16) begin
            n_err++;
            $display("FAIL rst_fresh got q=%h r=%h c=%0d want q=%h r=%h c=16", got.q, got.r, c, e.q, e.r);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        exp_t        e;
        exp_t        got;
        int          c;
        logic [15:0] a;
        logic [7:0]  b;
        logic [23:0] recon;
        for (int k = 0; k < 20; k++) begin
            a = 16'($urandom_range(0, 65535));
            b = 8'($urandom_range(1, 255));
            issue(a, b);
            wait_done(c);
            pop_exp(e);
            got = {quotient, remainder, div_by_zero};
            n_cmp++;
            if (got !== e || c !== 16) begin
                n_err++;
                $display("FAIL rand_result[%0d] %h/%h got q=%h r=%h c=%0d want q=%h r=%h c=16",
                         k, a, b, got.q, got.r, c, e.q, e.r);
            end
            recon = 24'(quotient) * 24'(b) + 24'(remainder);
            n_cmp++;
            if (recon !== 24'(a) || !(remainder < b)) begin
                n_err++;
                $display("FAIL rand_mul_check[%0d] got q*d+r=%h r=%h want %h r<%h", k, recon, remainder, a, b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
